serial_rx_50k: RTL
==================

// Module: serial_rx_50k
// PURPOSE
//   Receive-side end of the 50 kbit/s serial link driven by the Sender board.
//   Oversamples an asynchronous serial line with the 20 MHz system clock.
//   Recovers 8N1 frames: start bit low, DATA_BITS data bits LSB first, stop bit high.
//   Presents each good byte with a one-cycle valid strobe and flags bad stop bits.
// PARAMETERS
//   DIVISOR    400  clock_in cycles per bit (20 MHz / 400 = 50 kbit/s); even, >= 4
//   DATA_BITS  8    data bits per frame; range 5..8
// PORTS
//   clock_in     in   1          system clock, 20 MHz; all logic on posedge
//   reset_n      in   1          reset, asynchronous, active-low
//   rx_in        in   1          serial line; idle high; asynchronous to clock_in
//   data_out     out  DATA_BITS  last good received byte; holds until next good frame
//   data_valid   out  1          one-cycle pulse; data_out is new in this same cycle
//   frame_error  out  1          one-cycle pulse; stop bit sampled low
//   busy         out  1          high in every state except IDLE
// BEHAVIOUR
//   Interface: one clock, clock_in; reset_n is asynchronous and active-low.
//   Reset (reset_n=0):
//   - data_out=0, data_valid=0, frame_error=0, busy=0, state=IDLE.
//   - Counters cleared; both synchronizer flops set to 1 (idle line).
//   Synchronizer: rx_in passes through 2 flops to give rx_s; all decisions use rx_s only.
//   Counters:
//   - bit_cnt is $clog2(DIVISOR) bits wide and counts 0..DIVISOR-1.
//   - bit_idx counts 0..DATA_BITS-1.
//   Data is shifted in LSB first.
//   States:
//   - IDLE: on rx_s==0 -> START, bit_cnt=0.
//   - START: when bit_cnt==DIVISOR/2-1 (mid start bit):
//       rx_s==0 -> DATA, bit_cnt=0, bit_idx=0.
//       rx_s==1 -> IDLE. This is a glitch: no strobe, no error.
//   - DATA: when bit_cnt==DIVISOR-1: sample rx_s into shift[bit_idx], bit_cnt=0.
//       bit_idx==DATA_BITS-1 -> STOP; otherwise bit_idx+1.
//   - STOP: when bit_cnt==DIVISOR-1:
//       rx_s==1 -> data_out<=shift, data_valid=1 for 1 cycle, -> IDLE.
//       rx_s==0 -> frame_error=1 for 1 cycle, data_out unchanged, -> BREAK.
//   - BREAK: wait for rx_s==1, then -> IDLE. A held-low line never starts a false frame.
//   Latency:
//   - Line low edge to START entry: 3 cycles (2 synchronizer flops + IDLE registration).
//   - data_valid fires DIVISOR/2 + (DATA_BITS+1)*DIVISOR - 1 cycles after START entry.
//     Default: 3799 cycles.
//   Back-to-back frames:
//   - IDLE is re-entered at mid stop bit, so a start edge arriving at the end of the
//     stop bit is caught.
//   - No idle gap between frames is required.
//   Tolerance: centre sampling decodes correctly with a bit period within +/-2%
//     (392..408 cycles at default).
//   Strobes: data_valid and frame_error are never high together; both are registered
//     outputs.
//   Reset mid-frame: the frame is aborted immediately with no strobe, and the block
//     returns to IDLE with reset values.
// TESTING
//   1. Send 0xA5 at 400 cycles/bit ->
//      data_out=0xA5; exactly one data_valid pulse, 3800..3804 cycles after the start edge.
//   2. Send 0x00 then 0xFF back-to-back, no idle gap ->
//      two data_valid pulses with data_out 0x00 then 0xFF, about 4000 cycles apart; no frame_error.
//   3. Drive rx_in low for 100 cycles, then high ->
//      busy rises, then returns to 0 by cycle 205; no data_valid, no frame_error.
//   4. After a good 0xA5, send 0x3C with the stop bit held low for 2000 cycles ->
//      one frame_error pulse; data_out stays 0xA5; no data_valid; busy falls only after
//      rx_in returns high.
//   5. Send 0x3C at 392 and then 408 cycles/bit ->
//      data_out=0x3C with data_valid in both cases.
//   6. Assert reset_n=0 during bit 4 of a frame ->
//      all outputs 0 at once. Release reset and send 0x5A -> data_out=0x5A, one data_valid.

Source files
------------

// File: rtl/serial_rx_50k.sv
// 8N1 serial receiver: two-flop synchronizer, centre-sampling bit timer, frame FSM.
// Presents each good byte with a one-cycle data_valid; a low stop bit gives frame_error.
module serial_rx_50k #(
   parameter int DIVISOR   = 400,
   parameter int DATA_BITS = 8
) (
   input  logic                 clock_in,
   input  logic                 reset_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int CNT_W = $clog2(DIVISOR);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR/2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, rx_s_q;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;

   // Line idles high, so the synchronizer resets to 1 to avoid a false start.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= rx_in;
         rx_s_q  <= sync1_q;
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            bit_cnt_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            // A start bit that is gone by its midpoint was a glitch.
            if (bit_cnt_q == CNT_HALF) begin
               bit_cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (bit_cnt_q == CNT_FULL) begin
               bit_cnt_d          = '0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == IDX_LAST) state_d = S_STOP;
               else bit_idx_d = bit_idx_q + IDX_W'(1);
            end
         end
         S_STOP: begin
            // Decided at mid stop bit, so a start edge right after the stop bit is caught.
            if (bit_cnt_q == CNT_FULL) begin
               bit_cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            bit_cnt_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
         end
      endcase
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign frame_error = ferr_q;
   assign busy        = (state_q != S_IDLE);

endmodule
